serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder controller. It time-shares one full-adder cell, built internally from two half-adder instances plus an OR, across all operand bits, processing one bit per clock, LSB first.
- It sequences operand loading, the per-bit carry register and the result capture behind a start/busy/done handshake.
- It is the area-minimal adder option for slow control paths in the design.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 1.

Ports:
- clk    input   1   system clock; all state updates on the rising edge.
- rst    input   1   synchronous, active-high reset.
- start  input   1   request an addition; sampled only in IDLE or DONE.
- a      input   W   operand A; captured on the accepting edge.
- b      input   W   operand B; captured on the accepting edge.
- c_in   input   1   carry-in; captured on the accepting edge.
- busy   output  1   high while the addition is in progress (state RUN).
- done   output  1   one-cycle pulse; sum and c_out are valid and new.
- sum    output  W   registered result, a+b+c_in mod 2^W.
- c_out  output  1   registered carry-out of bit W-1.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, c_out=0, all internal shift, carry and counter registers=0.
  - rst has priority over every other input, including start on the same edge.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE:
  - start=1 loads the shift_a/shift_b registers from a/b, loads carry from c_in, clears bit counter to 0, and goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Half adder 1 computes shift_a[0] ^ shift_b[0] and the AND of the same two bits.
  - Half adder 2 combines that XOR result with carry.
  - Result bit = XOR output of half adder 2. New carry = OR of both half-adder carries.
  - Result bit shifts into the MSB of the internal result shift register (right shift); shift_a and shift_b shift right by 1.
  - Counter increments.
  - When the counter reaches W-1 on the current edge (the last bit):
    - sum <= completed result register including this bit.
    - c_out <= new carry.
    - Go to DONE.
  - start is ignored in RUN; operands and result are not disturbed.
- DONE (exactly one cycle):
  - done=1.
  - start=1 accepts a new operation exactly as in IDLE and goes to RUN (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Latency: accepted at edge 0; busy high for exactly W cycles; done high in cycle W+1 counted from the accepting edge. Throughput is one addition per W+1 cycles.
- sum and c_out change only on entry to DONE; they hold their value through IDLE and the following RUN until the next completion.
- a, b and c_in are don't-care except on the accepting edge. Changing them during RUN has no effect.
- W=1: a single RUN cycle; the counter compares 0 == W-1 immediately.
- Counter width = max(1, clog2(W)); no wrap-around beyond W-1 ever occurs.
- Reset mid-RUN: the operation is abandoned, outputs are zeroed, no done pulse, and the next start behaves normally.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → busy=0, done=0, sum=8'h00, c_out=0; outputs stay at 0 for 5 further cycles.
- Basic add (W=8): a=8'h0F, b=8'h01, c_in=0, start pulse → busy=1 for 8 cycles, then done=1 for 1 cycle with sum=8'h10, c_out=0.
- Full carry ripple: a=8'hA5, b=8'h5A, c_in=1 → sum=8'h00, c_out=1. Also a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1.
- Start during RUN ignored: start a=8'h03, b=8'h04; pulse start with a=8'hFF, b=8'hFF at cycle 3 of RUN → single done, sum=8'h07, c_out=0, busy never extended.
- Back-to-back: hold start=1 with a=8'h01, b=8'h01 then a=8'h80, b=8'h80 in the DONE cycle → first done gives sum=8'h02, c_out=0; second done arrives exactly 9 cycles later with sum=8'h00, c_out=1.
- Reset mid-operation and W=1 build:
  - rst=1 at RUN cycle 4 → busy=0, no done, sum=0; a fresh start with a=8'h7F, b=8'h01 gives sum=8'h80.
  - W=1 with a=1, b=1, c_in=1 → busy 1 cycle, sum=1, c_out=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Half-adder cell: sum and carry of two bits.
// Latency: combinational.
// Backpressure: none.
module serial_add_half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

// Bit-serial W-bit adder: one shared full-adder cell, one bit per clock, LSB first.
// Latency: busy for W cycles after the accepting edge, done pulses in cycle W+1.
// Backpressure: start is only accepted in IDLE or DONE; ignored while busy.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_a_q, shift_a_d;
    logic [W-1:0]   shift_b_q, shift_b_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           c_out_q, c_out_d;

    logic           accept;
    logic           last_bit;
    logic           ha1_s, ha1_c, ha2_s, ha2_c;
    logic           carry_new;
    logic [W-1:0]   res_shifted;

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (cnt_q == CW'(W - 1));

    serial_add_half_adder u_ha1 (
        .x_i (shift_a_q[0]),
        .y_i (shift_b_q[0]),
        .s_o (ha1_s),
        .c_o (ha1_c)
    );

    serial_add_half_adder u_ha2 (
        .x_i (ha1_s),
        .y_i (carry_q),
        .s_o (ha2_s),
        .c_o (ha2_c)
    );

    assign carry_new = ha1_c | ha2_c;
    // New bit enters at the MSB; after W shifts bit 0 of the sum sits at position 0.
    assign res_shifted = W'({ha2_s, res_q} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        c_out_d   = c_out_q;
        if (accept) begin
            shift_a_d = a;
            shift_b_d = b;
            carry_d   = c_in;
            cnt_d     = '0;
        end else if (state_q == S_RUN) begin
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            res_d     = res_shifted;
            carry_d   = carry_new;
            // Counter parks at zero on the last bit so it never exceeds W-1.
            cnt_d     = last_bit ? '0 : cnt_q + CW'(1);
            if (last_bit) begin
                sum_d   = res_shifted;
                c_out_d = carry_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            c_out_q   <= 1'b0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            c_out_q   <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized bench for serial_add_ctrl at W=8 and W=1.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, c_in, busy, done, c_out;
    logic [W-1:0] a, b, sum;
    logic         start1, a1, b1, c1, busy1, done1, sum1, cout1;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;
    int last_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    serial_add_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one addition and follow it to its done pulse; inj>0 pulses a stray start in that RUN cycle.
    task automatic op(input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                      input int inj, input string tag);
        logic [8:0] expv;
        logic [7:0] prev_sum;
        logic       prev_c;
        logic       held_ok;
        int         n;
        expv     = {1'b0, aa} + {1'b0, bb} + {8'd0, ci};
        prev_sum = sum;
        prev_c   = c_out;
        a = aa; b = bb; c_in = ci; start = 1'b1;
        tick();
        start   = 1'b0;
        n       = 0;
        held_ok = 1'b1;
        while (busy === 1'b1 && n < 20) begin
            n++;
            if (done !== 1'b0 || sum !== prev_sum || c_out !== prev_c) held_ok = 1'b0;
            a    = 8'($urandom);
            b    = 8'($urandom);
            c_in = 1'($urandom);
            if (n == inj) begin
                a = 8'hFF; b = 8'hFF; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, ".busy_cycles"}, n, W);
        chk({tag, ".held"}, {31'd0, held_ok}, 32'd1);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".sum"}, {24'd0, sum}, {24'd0, expv[7:0]});
        chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, expv[8]});
        last_done = cyc;
    endtask

    task automatic to_idle(input string tag);
        tick();
        chk({tag, ".pulse_end"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int t1;
        int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        tick(); tick();
        chk("reset", {21'd0, busy, done, c_out, sum}, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({busy, done, c_out, sum} !== 11'd0) seen++;
        end
        chk("idle_quiet", seen, 0);

        op(8'h0F, 8'h01, 1'b0, 0, "basic");
        to_idle("basic");
        op(8'hA5, 8'h5A, 1'b1, 0, "ripple1");
        to_idle("ripple1");
        op(8'hFF, 8'h01, 1'b0, 0, "ripple2");
        to_idle("ripple2");
        op(8'h03, 8'h04, 1'b0, 3, "start_in_run");
        to_idle("start_in_run");

        op(8'h01, 8'h01, 1'b0, 0, "b2b_first");
        t1 = last_done;
        op(8'h80, 8'h80, 1'b0, 0, "b2b_second");
        chk("b2b_spacing", last_done - t1, 9);
        to_idle("b2b");

        for (int i = 0; i < 30; i++) begin
            op(8'($urandom), 8'($urandom), 1'($urandom), 0, "rnd");
            if ($urandom_range(1, 0) == 1) begin
                to_idle("rnd");
                repeat ($urandom_range(3, 0)) tick();
            end
        end
        repeat (2) tick();

        a = 8'h03; b = 8'h04; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", {21'd0, busy, done, c_out, sum}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("rst_mid_no_done", seen, 0);
        op(8'h7F, 8'h01, 1'b0, 0, "post_rst");
        to_idle("post_rst");

        for (int i = 0; i < 8; i++) begin
            int s;
            a1 = i[2]; b1 = i[1]; c1 = i[0];
            s  = i[2] + i[1] + i[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1.busy", {30'd0, busy1, done1}, 32'd2);
            tick();
            chk("w1.done", {30'd0, busy1, done1}, 32'd1);
            chk("w1.sum", {31'd0, sum1}, s % 2);
            chk("w1.c_out", {31'd0, cout1}, s / 2);
            tick();
            chk("w1.idle", {30'd0, busy1, done1}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
